bxu_prog_mem: RTL and testbench

//   Loadable, synchronous-read program memory for the BXU sequencer; successor to fixed 4-word programs.

---
 rtl/bxu_prog_mem_pkg.sv | 19 +
 rtl/bxu_prog_mem_if.sv | 32 +++
 rtl/bxu_prog_mem_ram.sv | 28 ++
 rtl/bxu_prog_mem.sv | 122 ++++++++++++
 tb/tb_bxu_prog_mem.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bxu_prog_mem_pkg.sv
// Shared constants for the BXU program memory: opcode encodings, FSM
// state encoding and a word-packing helper used by benches and defaults.
package bxu_pkg;

    localparam int BXU_OPC_W = 4;

    localparam logic [BXU_OPC_W-1:0] BXU_OPC_IN  = 4'b1011;
    localparam logic [BXU_OPC_W-1:0] BXU_OPC_OUT = 4'b0011;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    // Instruction word layout: {operand, opcode}
    function automatic logic [15:0] bxu_word(input logic [11:0] operand,
                                             input logic [BXU_OPC_W-1:0] opcode);
        return {operand, opcode};
    endfunction

endpackage

// File: rtl/bxu_prog_mem_if.sv
// Load and fetch ports of the BXU program memory.
// master: host loader / BXU core side; slave: the memory.
interface bxu_prog_mem_if
    import bxu_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 16,
    parameter int DEPTH_LOG2    = 6
);
    logic                     ld_start;
    logic                     ld_valid;
    logic [DATA_BITWIDTH-1:0] ld_data;
    logic                     ld_last;
    logic                     ld_ready;
    logic                     busy;
    logic [DEPTH_LOG2:0]      prog_len;
    logic                     fetch_req;
    logic [ADDR_BITWIDTH-1:0] fetch_addr;
    logic                     fetch_valid;
    logic [DATA_BITWIDTH-1:0] fetch_data;
    logic                     fetch_perr;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        input  ld_ready, busy, prog_len, fetch_valid, fetch_data, fetch_perr
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        output ld_ready, busy, prog_len, fetch_valid, fetch_data, fetch_perr
    );
endinterface

// File: rtl/bxu_prog_mem_ram.sv
// Storage array for the BXU program memory: one write port, one
// registered read port. Contents are deliberately not reset.
module bxu_prog_ram
    import bxu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Write on accepted load word; read register only advances on a fetch
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/bxu_prog_mem.sv
// BXU program memory: loadable over a valid/ready stream, fetched with
// one-cycle latency. Fetches at or beyond prog_len return NOP_WORD.
// Optional build macro BXU_PROG_PARITY_EN adds an even-parity bit per
// stored word and flags mismatches on fetch_perr.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_RUN  | program usable, fetches served, load port not ready
// ST_LOAD | host streaming words in, fetches ignored, prog_len = 0
module bxu_prog_mem
    import bxu_pkg::*;
#(
    parameter int                       DATA_BITWIDTH = 16,
    parameter int                       ADDR_BITWIDTH = 16,
    parameter int                       DEPTH_LOG2    = 6,
    parameter logic [DATA_BITWIDTH-1:0] NOP_WORD      = '0
) (
    input logic          clk,
    input logic          rst,
    bxu_prog_mem_if.slave bus
);
`ifdef BXU_PROG_PARITY_EN
    localparam int RAM_W = DATA_BITWIDTH + 1;
`else
    localparam int RAM_W = DATA_BITWIDTH;
`endif

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2:0]   prog_len;
    logic                  ld_ready;
    logic                  accept;
    logic                  wr_final;
    logic                  fetch_en;
    logic                  fetch_valid;
    logic                  hit_q;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [RAM_W-1:0]      wr_word;
    logic [RAM_W-1:0]      rd_word;
    logic                  unused_addr_hi;

    // ld_start wins over a same-cycle word so a restart never stores it
    assign ld_ready = (state == ST_LOAD) && !bus.ld_start;
    assign accept   = bus.ld_valid && ld_ready;
    assign wr_final = bus.ld_last || (wptr == '1);
    assign fetch_en = bus.fetch_req && (state == ST_RUN);
    assign rd_idx   = bus.fetch_addr[DEPTH_LOG2-1:0];

    // Fetch address wraps modulo depth; upper bits carry no meaning here
    assign unused_addr_hi = ^bus.fetch_addr[ADDR_BITWIDTH-1:DEPTH_LOG2];

`ifdef BXU_PROG_PARITY_EN
    assign wr_word = {^bus.ld_data, bus.ld_data};
`else
    assign wr_word = bus.ld_data;
`endif

    // Load FSM, write pointer and committed program length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wptr     <= '0;
            prog_len <= '0;
        end else if (state == ST_RUN) begin
            if (bus.ld_start) begin
                state    <= ST_LOAD;
                wptr     <= '0;
                prog_len <= '0;
            end
        end else begin
            if (bus.ld_start) begin
                wptr <= '0;
            end else if (accept) begin
                if (wr_final) begin
                    state    <= ST_RUN;
                    prog_len <= (DEPTH_LOG2+1)'(wptr) + 1'b1;
                end else begin
                    wptr <= wptr + 1'b1;
                end
            end
        end
    end

    // Fetch pipeline: valid strobe plus in-program flag for the read word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            fetch_valid <= fetch_en;
            if (fetch_en) begin
                hit_q <= ((DEPTH_LOG2+1)'(rd_idx) < prog_len);
            end
        end
    end

    bxu_prog_ram #(
        .WIDTH      (RAM_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wptr),
        .wr_data (wr_word),
        .rd_en   (fetch_en),
        .rd_addr (rd_idx),
        .rd_data (rd_word)
    );

    assign bus.ld_ready    = ld_ready;
    assign bus.busy        = (state == ST_LOAD);
    assign bus.prog_len    = prog_len;
    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_data  = hit_q ? rd_word[DATA_BITWIDTH-1:0] : NOP_WORD;

`ifdef BXU_PROG_PARITY_EN
    // Stored word plus parity bit must XOR to zero; NOP returns never flag
    assign bus.fetch_perr  = fetch_valid && hit_q && (^rd_word);
`else
    assign bus.fetch_perr  = 1'b0;
`endif
endmodule

// File: tb/tb_bxu_prog_mem.sv
// Self-checking bench for bxu_prog_mem: fixed program table, full-depth
// load, restart, reset mid-load, streaming and randomized load/fetch.
module tb_bxu_prog_mem;
    import bxu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bxu_prog_mem_if #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(16), .DEPTH_LOG2(6)) bus ();

    bxu_prog_mem #(
        .DATA_BITWIDTH (16),
        .ADDR_BITWIDTH (16),
        .DEPTH_LOG2    (6),
        .NOP_WORD      (16'h0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          addr;
        logic [15:0] exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] ref_mem [64];
    int          ref_len = 0;
    logic [15:0] prog [64];
    logic [15:0] last_fd = 16'h0000;
    vec_t        vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected fetch result from the program model: wrap by depth, NOP past length
    function automatic logic [15:0] model_fetch(input int addr);
        int idx;
        idx = addr % 64;
        return (idx < ref_len) ? ref_mem[idx] : 16'h0000;
    endfunction

    // Issue one fetch (req left high so consecutive calls stream)
    task automatic fetch(input int addr, input string name);
        logic [15:0] exp;
        exp = model_fetch(addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr[15:0];
        @(negedge clk);
        chk({name, " valid"}, bus.fetch_valid, 1);
        chk({name, " data"},  bus.fetch_data,  exp);
        chk({name, " perr"},  bus.fetch_perr,  0);
        last_fd = exp;
    endtask

    task automatic fetch_idle();
        bus.fetch_req = 1'b0;
        @(negedge clk);
        chk("idle valid", bus.fetch_valid, 0);
    endtask

    task automatic start_load();
        bus.ld_start = 1'b1;
        @(negedge clk);
        bus.ld_start = 1'b0;
        chk("load busy", bus.busy, 1);
        chk("load len0", bus.prog_len, 0);
    endtask

    // Stream prog[0..n-1]; optional random valid gaps with junk data on idle cycles
    task automatic load_words(input int n, input bit use_last, input bit rand_valid, input string name);
        int i;
        int budget;
        i = 0;
        budget = 0;
        while (i < n && budget < 2000) begin
            bus.ld_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ld_data  = bus.ld_valid ? prog[i] : 16'($urandom);
            bus.ld_last  = use_last && bus.ld_valid && (i == n - 1);
            #1;
            if (bus.ld_valid && i == 0) chk({name, " ready"}, bus.ld_ready, 1);
            @(negedge clk);
            if (bus.ld_valid) i++;
            budget++;
        end
        if (budget >= 2000) chk({name, " load timeout"}, 0, 1);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic load_prog(input int n, input bit use_last, input bit rand_valid, input string name);
        start_load();
        load_words(n, use_last, rand_valid, name);
        for (int k = 0; k < n; k++) ref_mem[k] = prog[k];
        ref_len = n;
        chk({name, " busy"}, bus.busy, 0);
        chk({name, " len"},  bus.prog_len, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.ld_start   = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. reset state and empty-program fetches
        chk("rst len",   bus.prog_len,    0);
        chk("rst ready", bus.ld_ready,    0);
        chk("rst busy",  bus.busy,        0);
        chk("rst valid", bus.fetch_valid, 0);
        chk("rst data",  bus.fetch_data,  16'h0000);
        chk("rst perr",  bus.fetch_perr,  0);
        for (int a = 0; a < 4; a++) fetch(a, "empty");
        fetch_idle();

        // 2. fixed 4-word program, table-driven fetches
        prog[0] = bxu_word(12'h000, BXU_OPC_IN);
        prog[1] = bxu_word(12'h200, BXU_OPC_OUT);
        prog[2] = bxu_word(12'h02C, BXU_OPC_OUT);
        prog[3] = bxu_word(12'h020, BXU_OPC_OUT);
        load_prog(4, 1'b1, 1'b0, "prog4");
        vt[0] = '{0,  16'h000B};
        vt[1] = '{1,  16'h2003};
        vt[2] = '{2,  16'h02C3};
        vt[3] = '{3,  16'h0203};
        vt[4] = '{5,  16'h0000};
        vt[5] = '{65, 16'h2003};
        vt[6] = '{67, 16'h0203};
        vt[7] = '{63, 16'h0000};
        for (int v = 0; v < 8; v++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = vt[v].addr[15:0];
            @(negedge clk);
            chk($sformatf("tbl[%0d] valid", v), bus.fetch_valid, 1);
            chk($sformatf("tbl[%0d] data", v),  bus.fetch_data,  vt[v].exp);
            last_fd = vt[v].exp;
        end
        fetch_idle();

        // 3. full-depth load without ld_last, then a 65th word is refused
        for (int k = 0; k < 64; k++) prog[k] = 16'($urandom);
        load_prog(64, 1'b0, 1'b0, "full");
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hDEAD;
        #1;
        chk("w65 ready", bus.ld_ready, 0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("w65 len",  bus.prog_len, 64);
        chk("w65 busy", bus.busy, 0);
        fetch(0, "full0");
        fetch(63, "full63");
        fetch(127, "full127");
        fetch_idle();

        // 4. restart after 2 words; fetch ignored during load
        start_load();
        prog[0] = 16'h1111;
        prog[1] = 16'h2222;
        load_words(2, 1'b0, 1'b0, "part");
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'd1;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        chk("load fetch valid", bus.fetch_valid, 0);
        chk("load fetch hold",  bus.fetch_data,  last_fd);
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hBAD0;
        #1;
        chk("restart ready", bus.ld_ready, 0);
        bus.ld_valid = 1'b0;
        prog[0] = 16'hA5A0;
        prog[1] = 16'h5A51;
        prog[2] = 16'h3C32;
        load_prog(3, 1'b1, 1'b0, "reload");
        fetch(0, "re0");
        fetch(1, "re1");
        fetch(2, "re2");
        fetch(3, "re3");
        fetch_idle();

        // reset in the middle of a load
        start_load();
        prog[0] = 16'h7777;
        prog[1] = 16'h8888;
        load_words(2, 1'b0, 1'b0, "prerst");
        rst = 1'b1;
        #2;
        chk("midrst busy", bus.busy, 0);
        chk("midrst len",  bus.prog_len, 0);
        @(negedge clk);
        rst = 1'b0;
        ref_len = 0;
        fetch(0, "rst0");
        fetch(1, "rst1");
        fetch_idle();

        // 5. random valid gaps, then streamed and random fetches
        for (int k = 0; k < 20; k++) prog[k] = 16'($urandom);
        load_prog(20, 1'b1, 1'b1, "rand");
        for (int a = 0; a < 8; a++) fetch(a, "stream");
        for (int r = 0; r < 40; r++) fetch(int'($urandom_range(0, 65535)), "rfetch");
        fetch_idle();

`ifdef BXU_PROG_PARITY_EN
        // 6. corrupt one stored bit; only that address flags
        prog[0] = 16'h000B;
        prog[1] = 16'h2003;
        prog[2] = 16'h02C3;
        prog[3] = 16'h0203;
        load_prog(4, 1'b1, 1'b0, "par");
        u_dut.u_ram.mem[1][0] = ~u_dut.u_ram.mem[1][0];
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'd1;
        @(negedge clk);
        chk("perr bad valid", bus.fetch_valid, 1);
        chk("perr bad",       bus.fetch_perr,  1);
        fetch(0, "perr ok0");
        fetch(2, "perr ok2");
        fetch(10, "perr nop");
        fetch_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
